centroid_div_sched: RTL and testbench
=====================================

CENTROID_DIV_SCHED -- requirements
Module: centroid_div_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 1280, meaning active pixels per line and the x clamp bound.
REQ-002 SHALL have parameter IMG_H, default 720, meaning active lines per frame and the y clamp bound.
REQ-003 SHALL have parameter DIV_CYCLES, default 32, meaning cycles per quotient in the shared divider (equals dividend width).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port eof  input  1  end-of-frame pulse, one cycle wide, accumulators valid in same cycle.
REQ-007 SHALL have port m_x  input  32  sum of x positions of mask pixels.
REQ-008 SHALL have port m_y  input  32  sum of y positions of mask pixels.
REQ-009 SHALL have port m  input  20  count of mask pixels.
REQ-010 SHALL have port xcent  output  11  registered x centroid.
REQ-011 SHALL have port ycent  output  10  registered y centroid.
REQ-012 SHALL have port cent_valid  output  1  one-cycle pulse when xcent/ycent update.
REQ-013 SHALL have port empty_frame  output  1  registered, high when last completed frame had m==0.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port overrun  output  1  one-cycle pulse when eof is dropped.

Function
REQ-016 SHALL capture m_x, m_y, m into internal registers in the cycle eof is high and state is IDLE.
REQ-017 SHALL sequence one shared divider instance through states IDLE -> DIV_X -> DIV_Y -> DONE -> IDLE.
REQ-018 SHALL pulse the divider start on DIV_X entry with dividend m_x, then on DIV_Y entry with dividend m_y, divisor m both times.
REQ-019 SHALL advance DIV_X -> DIV_Y and DIV_Y -> DONE on the divider done pulse only.
REQ-020 SHALL, with eof sampled at cycle T and m!=0, assert cent_valid in cycle T+2*DIV_CYCLES+3 (T+67 at default) and update xcent/ycent in that same cycle.
REQ-021 SHALL stay in DONE exactly one cycle, then return to IDLE; eof is accepted again in the IDLE cycle that follows.
REQ-022 SHALL, when captured m==0, skip DIV_X/DIV_Y, go IDLE -> DONE, hold xcent/ycent at prior values, set empty_frame=1, pulse cent_valid at T+2.
REQ-023 SHALL clear empty_frame on the next cent_valid with m!=0.
REQ-024 SHALL clamp quotients: x > IMG_W-1 gives IMG_W-1, y > IMG_H-1 gives IMG_H-1, then truncate to 11/10 bits.
REQ-025 SHALL ignore eof arriving while busy=1 (registers untouched) and pulse overrun in that cycle.
REQ-026 SHALL treat eof coincident with DONE as busy (dropped, overrun pulsed).

Reset
REQ-027 SHALL on rst force state IDLE, xcent=0, ycent=0, cent_valid=0, empty_frame=0, busy=0, overrun=0, captured registers 0, and abort any in-flight division.
REQ-028 SHALL emit no cent_valid for a frame whose division was aborted by rst.

Configuration
REQ-029 SHALL, with macro CENTROID_ROUND_EN defined, divide (dividend + (m>>1)) saturated to 32'hFFFFFFFF, giving round-to-nearest.
REQ-030 SHALL, without CENTROID_ROUND_EN, divide the raw dividend, giving truncating floor division; latency identical in both builds.

Structure
REQ-031 SHALL place IMG_W/IMG_H defaults, dividend width 32, divisor width 20, output widths 11/10 and the state enum in shared package centroid_pkg.
REQ-032 SHALL implement the divider as sub-module centroid_serdiv: restoring, one quotient bit per cycle, start/done handshake, DIV_CYCLES cycles start-to-done.

Verification
REQ-033 SHALL cover: m=4, m_x=4000, m_y=2000, eof at T -> cent_valid at T+67, xcent=1000, ycent=500, empty_frame=0.
REQ-034 SHALL cover: m=0 after a valid frame -> cent_valid at T+2, empty_frame=1, xcent/ycent unchanged.
REQ-035 SHALL cover: second eof at T+10 while busy -> overrun pulse at T+10, first frame result unchanged at T+67.
REQ-036 SHALL cover: m=3, m_x=5, m_y=4 -> xcent=1, ycent=1 without CENTROID_ROUND_EN; xcent=2, ycent=1 with it.
REQ-037 SHALL cover: m=1, m_x=5000, m_y=900 -> xcent=1279, ycent=719 (clamped).
REQ-038 SHALL cover: rst asserted at T+40 mid DIV_Y -> all outputs 0 immediately, no cent_valid, next eof processed normally.

Source files
------------

// File: rtl/centroid_pkg.sv
// Shared constants, FSM state type and clamp helper for the
// centroid divider scheduler.
package centroid_pkg;

  localparam int IMG_W_DEF = 1280;
  localparam int IMG_H_DEF = 720;
  localparam int DVD_W     = 32;
  localparam int DVS_W     = 20;
  localparam int XC_W      = 11;
  localparam int YC_W      = 10;

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    DONE
  } state_e;

  function automatic logic [DVD_W-1:0] clamp_q(
    input logic [DVD_W-1:0] q,
    input logic [DVD_W-1:0] lim
  );
    return (q > lim) ? lim : q;
  endfunction

endpackage

// File: rtl/centroid_serdiv.sv
// Restoring serial divider, one quotient bit per cycle.
// Ports: clk, rst (async high), start_i, dvd_i, dvs_i -> done_o pulse, quot_o.
module centroid_serdiv
  import centroid_pkg::*;
#(
  parameter int DIV_CYCLES = DVD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dvd_i,
  input  logic [DVS_W-1:0] dvs_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quot_o
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             done_q;
  logic [DVS_W-1:0] rem_q;
  logic [DVD_W-1:0] quot_q;

  logic [DVS_W-1:0] rem_s;
  logic [DVS_W-1:0] rem_d;
  logic [DVD_W-1:0] quot_s;
  logic [DVD_W-1:0] quot_d;
  logic [DVS_W:0]   sh;
  logic             ge;
  logic             last;

  // The start cycle already performs the first iteration on the
  // incoming dividend, so done lands DIV_CYCLES cycles after start.
  always_comb begin
    rem_s  = start_i ? '0 : rem_q;
    quot_s = start_i ? dvd_i : quot_q;
    sh     = {rem_s, quot_s[DVD_W-1]};
    ge     = sh >= {1'b0, dvs_i};
    rem_d  = ge ? DVS_W'(sh - {1'b0, dvs_i})
                : sh[DVS_W-1:0];
    quot_d = {quot_s[DVD_W-2:0], ge};
  end

  assign last = cnt_q == CW'(DIV_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
      quot_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        cnt_q  <= CW'(1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        cnt_q  <= cnt_q + CW'(1);
        if (last) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/centroid_div_sched.sv
// Frame centroid: captures sums on eof, runs x then y through one
// shared serial divider, clamps and publishes with cent_valid.
// Ports: clk, rst, eof, m_x, m_y, m -> xcent, ycent, cent_valid,
// empty_frame, busy, overrun. Macro CENTROID_ROUND_EN: round-to-nearest.
module centroid_div_sched
  import centroid_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int DIV_CYCLES = DVD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eof,
  input  logic [DVD_W-1:0] m_x,
  input  logic [DVD_W-1:0] m_y,
  input  logic [DVS_W-1:0] m,
  output logic [XC_W-1:0]  xcent,
  output logic [YC_W-1:0]  ycent,
  output logic             cent_valid,
  output logic             empty_frame,
  output logic             busy,
  output logic             overrun
);

  state_e           state_q;
  logic [DVD_W-1:0] mx_q;
  logic [DVD_W-1:0] my_q;
  logic [DVS_W-1:0] m_q;
  logic [DVD_W-1:0] xq_q;
  logic             start_q;

  logic             div_start;
  logic             div_done;
  logic [DVD_W-1:0] raw;
  logic [DVD_W-1:0] dvd;
  logic [DVD_W-1:0] quot;

  assign busy    = state_q != IDLE;
  assign overrun = eof & busy;

  // The y division starts on the x done pulse itself, keeping the
  // two divisions back-to-back.
  assign div_start = start_q
                   | ((state_q == DIV_X) & div_done);
  assign raw = start_q ? mx_q : my_q;

`ifdef CENTROID_ROUND_EN
  logic [DVD_W:0] sum;
  assign sum = {1'b0, raw} + (DVD_W+1)'(m_q >> 1);
  assign dvd = sum[DVD_W] ? '1 : sum[DVD_W-1:0];
`else
  assign dvd = raw;
`endif

  centroid_serdiv #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .dvd_i   (dvd),
    .dvs_i   (m_q),
    .done_o  (div_done),
    .quot_o  (quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mx_q        <= '0;
      my_q        <= '0;
      m_q         <= '0;
      xq_q        <= '0;
      start_q     <= 1'b0;
      xcent       <= '0;
      ycent       <= '0;
      cent_valid  <= 1'b0;
      empty_frame <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      cent_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (eof) begin
            mx_q <= m_x;
            my_q <= m_y;
            m_q  <= m;
            if (m != '0) begin
              state_q <= DIV_X;
              start_q <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DIV_X: begin
          if (div_done) begin
            xq_q    <= quot;
            state_q <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) state_q <= DONE;
        end
        DONE: begin
          cent_valid <= 1'b1;
          state_q    <= IDLE;
          if (m_q == '0) begin
            empty_frame <= 1'b1;
          end else begin
            empty_frame <= 1'b0;
            // quot still holds the y quotient here
            xcent <= XC_W'(clamp_q(xq_q, DVD_W'(IMG_W - 1)));
            ycent <= YC_W'(clamp_q(quot, DVD_W'(IMG_H - 1)));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_div_sched.sv
// Directed bench for centroid_div_sched: latency, empty frame,
// overrun, rounding, clamping and mid-division reset.
module tb_centroid_div_sched;

  logic        clk;
  logic        rst;
  logic        eof;
  logic [31:0] m_x;
  logic [31:0] m_y;
  logic [19:0] m;
  logic [10:0] xcent;
  logic [9:0]  ycent;
  logic        cent_valid;
  logic        empty_frame;
  logic        busy;
  logic        overrun;

  int errs;
  int checks;
  int cva;
  int cvn;

  centroid_div_sched dut (
    .clk         (clk),
    .rst         (rst),
    .eof         (eof),
    .m_x         (m_x),
    .m_y         (m_y),
    .m           (m),
    .xcent       (xcent),
    .ycent       (ycent),
    .cent_valid  (cent_valid),
    .empty_frame (empty_frame),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // eof in cycle T; cycle T+n is sampled 2ns after its first edge.
  task automatic frame(
    input  logic [31:0] mx,
    input  logic [31:0] my,
    input  logic [19:0] mm,
    input  int          ovr_at,
    input  int          rst_at,
    output int          cv_at,
    output int          cv_cnt
  );
    cv_at  = -1;
    cv_cnt = 0;
    @(posedge clk); #1;
    m_x = mx;
    m_y = my;
    m   = mm;
    eof = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 1) eof = 1'b0;
      if (n == ovr_at) begin
        eof = 1'b1;
        m_x = 32'd7;
        m_y = 32'd7;
        m   = 20'd7;
      end
      if (n == ovr_at + 1) eof = 1'b0;
      if (n == rst_at) rst = 1'b1;
      #1;
      if (n == 1) chk("busy_t1", 32'(busy), 1);
      if (n == ovr_at) chk("ovr_pulse", 32'(overrun), 1);
      if (n == rst_at) begin
        chk("rst_x", 32'(xcent), 0);
        chk("rst_y", 32'(ycent), 0);
        chk("rst_cv", 32'(cent_valid), 0);
        chk("rst_empty", 32'(empty_frame), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(overrun), 0);
      end
      if (cent_valid) begin
        cv_cnt++;
        if (cv_at < 0) cv_at = n;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    eof    = 1'b0;
    m_x    = '0;
    m_y    = '0;
    m      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", 32'(xcent), 0);
    chk("reset_y", 32'(ycent), 0);
    chk("reset_cv", 32'(cent_valid), 0);
    chk("reset_empty", 32'(empty_frame), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ovr", 32'(overrun), 0);
    rst = 1'b0;

    frame(32'd4000, 32'd2000, 20'd4, 0, 0, cva, cvn);
    chk("a_lat", 32'(cva), 67);
    chk("a_cnt", 32'(cvn), 1);
    chk("a_x", 32'(xcent), 1000);
    chk("a_y", 32'(ycent), 500);
    chk("a_empty", 32'(empty_frame), 0);
    chk("a_idle", 32'(busy), 0);

    frame(32'd123, 32'd456, 20'd0, 0, 0, cva, cvn);
    chk("e_lat", 32'(cva), 2);
    chk("e_cnt", 32'(cvn), 1);
    chk("e_empty", 32'(empty_frame), 1);
    chk("e_x", 32'(xcent), 1000);
    chk("e_y", 32'(ycent), 500);

    frame(32'd3000, 32'd1500, 20'd4, 10, 0, cva, cvn);
    chk("o_lat", 32'(cva), 67);
    chk("o_cnt", 32'(cvn), 1);
    chk("o_x", 32'(xcent), 750);
    chk("o_y", 32'(ycent), 375);
    chk("o_empty", 32'(empty_frame), 0);

    frame(32'd5, 32'd4, 20'd3, 0, 0, cva, cvn);
    chk("r_lat", 32'(cva), 67);
`ifdef CENTROID_ROUND_EN
    chk("r_x", 32'(xcent), 2);
`else
    chk("r_x", 32'(xcent), 1);
`endif
    chk("r_y", 32'(ycent), 1);

    frame(32'd5000, 32'd900, 20'd1, 0, 0, cva, cvn);
    chk("c_lat", 32'(cva), 67);
    chk("c_x", 32'(xcent), 1279);
    chk("c_y", 32'(ycent), 719);

    frame(32'd4000, 32'd2000, 20'd4, 0, 40, cva, cvn);
    chk("abort_cnt", 32'(cvn), 0);
    chk("abort_x", 32'(xcent), 0);

    frame(32'd2000, 32'd1000, 20'd4, 0, 0, cva, cvn);
    chk("post_lat", 32'(cva), 67);
    chk("post_x", 32'(xcent), 500);
    chk("post_y", 32'(ycent), 250);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
